td4_run_ctrl: RTL and testbench

//  Execution controller for the TD4 core: owns the core's clock enable (CE)
//  and sequences it in HALT / RUN / single-STEP modes, with a programmable

---
 rtl/td4_run_ctrl.sv | 134 +++++++++++++
 tb/tb_td4_run_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_run_ctrl.sv
// TD4 execution controller: gates the core clock enable in HALT/RUN/STEP/BRK modes.
// o_ce is combinational from state and inputs; button edges act one cycle after sampling.
module td4_run_ctrl #(
    parameter int DIVW = 8,
    parameter int ICW  = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_stop,
    input  logic            i_step,
    input  logic [DIVW-1:0] i_div,
    input  logic            i_bp_en,
    input  logic [3:0]      i_bp_addr,
    input  logic [3:0]      i_pc,
    output logic            o_ce,
    output logic            o_running,
    output logic            o_bp_hit,
    output logic [ICW-1:0]  o_icount
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_BRK  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DIVW-1:0] r_cnt;
    logic [DIVW-1:0] w_cnt_nxt;
    logic            r_skip;
    logic            w_skip_nxt;
    logic            r_start_d;
    logic            r_stop_d;
    logic            r_step_d;
    logic [ICW-1:0]  r_icount;
    logic            w_ce;

    logic w_start_ev;
    logic w_stop_ev;
    logic w_step_ev;
    logic w_fire;
    logic w_hit;

    assign w_start_ev = i_start & ~r_start_d;
    assign w_stop_ev  = i_stop  & ~r_stop_d;
    assign w_step_ev  = i_step  & ~r_step_d;
    // >= rather than == so a DIV lowered below the running count fires at once
    assign w_fire     = (r_cnt >= i_div);
    assign w_hit      = i_bp_en & (i_pc == i_bp_addr) & ~r_skip;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_skip_nxt  = r_skip;
        w_ce        = 1'b0;
        case (r_state)
            S_HALT: begin
                if (!w_stop_ev) begin
                    if (w_start_ev) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                        w_skip_nxt  = 1'b0;
                    end else if (w_step_ev) begin
                        w_state_nxt = S_STEP;
                    end
                end
            end
            S_RUN: begin
                if (w_stop_ev) begin
                    w_state_nxt = S_HALT;
                end else if (w_fire) begin
                    w_cnt_nxt = '0;
                    if (w_hit) begin
                        w_state_nxt = S_BRK;
                    end else begin
                        w_ce       = 1'b1;
                        w_skip_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DIVW'(1);
                end
            end
            S_STEP: begin
                w_ce        = 1'b1;
                w_skip_nxt  = 1'b0;
                w_state_nxt = S_HALT;
            end
            S_BRK: begin
                if (w_stop_ev) begin
                    w_state_nxt = S_HALT;
                end else if (w_start_ev) begin
                    // resume must execute the instruction parked at the breakpoint
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                    w_skip_nxt  = 1'b1;
                end else if (w_step_ev) begin
                    w_state_nxt = S_STEP;
                end
            end
            default: w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_HALT;
            r_cnt     <= '0;
            r_skip    <= 1'b0;
            r_start_d <= 1'b1;
            r_stop_d  <= 1'b1;
            r_step_d  <= 1'b1;
            r_icount  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_skip    <= w_skip_nxt;
            r_start_d <= i_start;
            r_stop_d  <= i_stop;
            r_step_d  <= i_step;
            if (w_ce) begin
                r_icount <= r_icount + ICW'(1);
            end
        end
    end

    assign o_ce      = w_ce;
    assign o_running = (r_state == S_RUN);
    assign o_bp_hit  = (r_state == S_BRK);
    assign o_icount  = r_icount;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Randomized and directed bench for td4_run_ctrl against a cycle-level reference model.
module tb_td4_run_ctrl;

    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_BRK  = 3;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_stop;
    logic        i_step;
    logic [7:0]  i_div;
    logic        i_bp_en;
    logic [3:0]  i_bp_addr;
    logic [3:0]  i_pc;
    logic        o_ce;
    logic        o_running;
    logic        o_bp_hit;
    logic [15:0] o_icount;
    logic        o_ce4;
    logic        o_running4;
    logic        o_bp_hit4;
    logic [3:0]  o_icount4;

    int n_chk;
    int n_err;

    int       m_mode;
    int       m_since;
    bit       m_skip;
    int       m_icnt;
    logic [3:0] m_pc;
    logic     m_pstart;
    logic     m_pstop;
    logic     m_pstep;

    td4_run_ctrl #(.DIVW(8), .ICW(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_stop(i_stop), .i_step(i_step),
        .i_div(i_div), .i_bp_en(i_bp_en), .i_bp_addr(i_bp_addr), .i_pc(i_pc),
        .o_ce(o_ce), .o_running(o_running), .o_bp_hit(o_bp_hit), .o_icount(o_icount)
    );

    td4_run_ctrl #(.DIVW(8), .ICW(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_stop(i_stop), .i_step(i_step),
        .i_div(i_div), .i_bp_en(i_bp_en), .i_bp_addr(i_bp_addr), .i_pc(i_pc),
        .o_ce(o_ce4), .o_running(o_running4), .o_bp_hit(o_bp_hit4), .o_icount(o_icount4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_HALT;
        m_since  = 0;
        m_skip   = 1'b0;
        m_icnt   = 0;
        m_pc     = 4'd0;
        m_pstart = 1'b1;
        m_pstop  = 1'b1;
        m_pstep  = 1'b1;
    endtask

    function automatic bit model_hit();
        return i_bp_en && (i_pc == i_bp_addr) && !m_skip;
    endfunction

    function automatic bit model_ce();
        bit ev_stop;
        ev_stop = i_stop && !m_pstop;
        if (m_mode == M_STEP) return 1'b1;
        if (m_mode == M_RUN) return (m_since >= int'(i_div)) && !model_hit() && !ev_stop;
        return 1'b0;
    endfunction

    task automatic model_step(input bit ce);
        bit ev_start, ev_stop, ev_step, hit;
        ev_start = i_start && !m_pstart;
        ev_stop  = i_stop  && !m_pstop;
        ev_step  = i_step  && !m_pstep;
        hit      = model_hit();
        case (m_mode)
            M_HALT: if (!ev_stop) begin
                if (ev_start) begin m_mode = M_RUN; m_since = 0; m_skip = 1'b0; end
                else if (ev_step) m_mode = M_STEP;
            end
            M_RUN: if (ev_stop) m_mode = M_HALT;
                   else if (m_since >= int'(i_div)) begin
                       m_since = 0;
                       if (hit) m_mode = M_BRK;
                   end else m_since++;
            M_STEP: m_mode = M_HALT;
            default: if (ev_stop) m_mode = M_HALT;
                     else if (ev_start) begin m_mode = M_RUN; m_since = 0; m_skip = 1'b1; end
                     else if (ev_step) m_mode = M_STEP;
        endcase
        if (ce) begin
            m_icnt++;
            m_pc   = m_pc + 4'd1;
            m_skip = 1'b0;
        end
        m_pstart = i_start;
        m_pstop  = i_stop;
        m_pstep  = i_step;
    endtask

    // Called just after a falling edge with inputs settled; returns after the next falling edge.
    task automatic tick();
        bit ce;
        #1;
        ce = model_ce();
        chk("ce", o_ce, ce);
        chk("running", o_running, m_mode == M_RUN);
        chk("bp_hit", o_bp_hit, m_mode == M_BRK);
        chk("icount", o_icount, m_icnt[15:0]);
        chk("icount4", o_icount4, m_icnt[3:0]);
        @(posedge clk);
        model_step(ce);
        @(negedge clk);
        i_pc = m_pc;
    endtask

    task automatic pulse_start(); i_start = 1'b1; tick(); i_start = 1'b0; endtask
    task automatic pulse_stop();  i_stop  = 1'b1; tick(); i_stop  = 1'b0; endtask
    task automatic pulse_step();  i_step  = 1'b1; tick(); i_step  = 1'b0; endtask

    initial begin
        int n;
        int ic0;
        logic [3:0] bpa;
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        i_start = 1'b1; i_stop = 1'b0; i_step = 1'b0;
        i_div = 8'd0; i_bp_en = 1'b0; i_bp_addr = 4'd0; i_pc = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ce", o_ce, 0);
        chk("rst_running", o_running, 0);
        chk("rst_icount", o_icount, 0);
        rst = 1'b0;
        model_reset();

        // START held high through reset must not start a run
        repeat (3) tick();
        chk("held_start_norun", o_running, 0);
        i_start = 1'b0;
        tick();

        // DIV=0: CE on five consecutive cycles
        pulse_start();
        n = 0;
        for (int i = 0; i < 5; i++) begin n += o_ce; tick(); end
        chk("div0_pulses", n, 5);
        chk("div0_icount", o_icount, 5);
        pulse_stop();
        tick();

        // DIV=3: one CE every fourth cycle
        i_div = 8'd3;
        pulse_start();
        n = 0;
        for (int i = 0; i < 16; i++) begin n += o_ce; tick(); end
        chk("div3_pulses", n, 4);
        chk("div3_running", o_running, 1);
        pulse_stop();
        tick();

        // breakpoint at PC=4, then resume executes it exactly once
        i_div = 8'd0; i_bp_en = 1'b1; i_bp_addr = 4'd4;
        pulse_start();
        for (int i = 0; i < 40 && !o_bp_hit; i++) tick();
        chk("bp_reached", o_bp_hit, 1);
        chk("bp_pc", i_pc, 4);
        tick();
        chk("bp_parked_pc", i_pc, 4);
        pulse_start();
        #1;
        chk("bp_resume_ce", o_ce, 1);
        tick();
        chk("bp_after_pc", i_pc, 5);
        repeat (6) tick();
        chk("bp_still_running", o_running, 1);
        pulse_stop();
        tick();

        // three single steps from HALT
        ic0 = int'(o_icount);
        for (int i = 0; i < 3; i++) begin pulse_step(); tick(); tick(); end
        chk("step3_count", int'(o_icount) - ic0, 3);
        chk("step3_halt", o_running, 0);

        // STEP from BRK executes the breakpoint instruction and halts
        bpa = m_pc + 4'd2;
        i_bp_addr = bpa;
        pulse_start();
        for (int i = 0; i < 40 && !o_bp_hit; i++) tick();
        chk("brk2_reached", o_bp_hit, 1);
        pulse_step();
        #1;
        chk("brk_step_ce", o_ce, 1);
        tick();
        chk("brk_step_bphit", o_bp_hit, 0);
        chk("brk_step_running", o_running, 0);
        chk("brk_step_pc", i_pc, bpa + 4'd1);
        i_bp_en = 1'b0;
        tick();

        // START and STOP on the same edge from HALT
        i_start = 1'b1; i_stop = 1'b1;
        tick();
        i_start = 1'b0; i_stop = 1'b0;
        tick();
        chk("start_stop_halt", o_running, 0);

        // STOP coinciding with a prescaler fire suppresses that CE
        i_div = 8'd2;
        pulse_start();
        tick(); tick();
        i_stop = 1'b1;
        #1;
        chk("stop_on_fire_ce", o_ce, 0);
        tick();
        i_stop = 1'b0;
        chk("stop_on_fire_halt", o_running, 0);
        tick();

        // random button activity, divider and breakpoint changes
        for (int i = 0; i < 1500; i++) begin
            i_start = ($urandom_range(0, 15) == 0);
            i_stop  = ($urandom_range(0, 40) == 0);
            i_step  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 30) == 0) i_div = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 50) == 0) i_bp_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 50) == 0) i_bp_addr = 4'($urandom_range(0, 15));
            tick();
        end
        i_start = 1'b0; i_stop = 1'b0; i_step = 1'b0;
        tick();
        pulse_stop();
        tick();

        // asynchronous reset in the middle of a run
        i_div = 8'd0; i_bp_en = 1'b0;
        pulse_start();
        repeat (3) tick();
        chk("prereset_running", o_running, 1);
        rst = 1'b1;
        #1;
        chk("midrst_ce", o_ce, 0);
        chk("midrst_icount", o_icount, 0);
        chk("midrst_running", o_running, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        i_pc = m_pc;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
